// File: rtl/radiant_coinc_trigger_if.sv
// Bus bundle for radiant_coinc_trigger: hit inputs, configuration, and trigger outputs.
// The master drives hits and configuration. The slave (the trigger) drives the outputs.
interface radiant_coinc_trigger_if #(
  parameter int unsigned NCHAN      = 24,
  parameter int unsigned OS_WIDTH   = 7,
  parameter int unsigned THR_WIDTH  = 6,
  parameter int unsigned HOLD_WIDTH = 8
);
  logic [NCHAN-1:0]      trig_i;
  logic [NCHAN-1:0]      en_i;
  logic [OS_WIDTH-1:0]   oneshot_len_i;
  logic [THR_WIDTH-1:0]  threshold_i;
  logic [HOLD_WIDTH-1:0] holdoff_i;
  logic                  count_clr_i;
  logic                  trigger_o;
  logic                  busy_o;
  logic [31:0]           trig_count_o;
  logic [NCHAN-1:0]      hit_mask_o;

  modport master (
    output trig_i, en_i, oneshot_len_i, threshold_i, holdoff_i, count_clr_i,
    input  trigger_o, busy_o, trig_count_o, hit_mask_o
  );

  modport slave (
    input  trig_i, en_i, oneshot_len_i, threshold_i, holdoff_i, count_clr_i,
    output trigger_o, busy_o, trig_count_o, hit_mask_o
  );
endinterface

// File: rtl/radiant_coinc_trigger.sv
// Per-channel oneshot coincidence trigger with holdoff/rearm FSM and a saturating trigger counter.
// Define RADIANT_TRIG_HIT_LATCH_EN to latch the contributing channel mask on each fire.
module radiant_coinc_trigger #(
  parameter int unsigned NCHAN      = 24,
  parameter int unsigned OS_WIDTH   = 7,
  parameter int unsigned THR_WIDTH  = 6,
  parameter int unsigned HOLD_WIDTH = 8
) (
  input  logic                    trig_clk_i,
  input  logic                    rst_n_i,
  radiant_coinc_trigger_if.slave  bus
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << THR_WIDTH) - 64'd1);

  typedef enum logic [1:0] {IDLE, FIRE, HOLDOFF, REARM} state_e;

  state_e                state_q, state_d;
  logic [NCHAN-1:0]      trig_prev_q;
  logic [OS_WIDTH-1:0]   os_cnt_q [NCHAN];
  logic [OS_WIDTH-1:0]   os_cnt_d [NCHAN];
  logic [NCHAN-1:0]      active;
  logic [NCHAN-1:0]      act_en;
  logic [31:0]           pop;
  logic [THR_WIDTH-1:0]  coinc_q, coinc_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [31:0]           tcount_q, tcount_d;

  // A held-high input never reloads; only a low-to-high transition does.
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      active[i] = (os_cnt_q[i] != '0);
      if (bus.trig_i[i] && !trig_prev_q[i]) begin
        os_cnt_d[i] = bus.oneshot_len_i;
      end else if (active[i]) begin
        os_cnt_d[i] = os_cnt_q[i] - 1'b1;
      end else begin
        os_cnt_d[i] = '0;
      end
    end
    act_en = active & bus.en_i;
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      pop = pop + 32'(act_en[i]);
    end
    coinc_d = (pop > CNT_MAX) ? '1 : THR_WIDTH'(pop);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.threshold_i != '0 && coinc_q >= bus.threshold_i) state_d = FIRE;
      end
      FIRE: begin
        hold_d  = bus.holdoff_i;
        state_d = (bus.holdoff_i == '0) ? REARM : HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_q <= HOLD_WIDTH'(1)) state_d = REARM;
        else                          hold_d  = hold_q - 1'b1;
      end
      REARM: begin
        if (coinc_q < bus.threshold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcount_d = tcount_q;
    if (bus.count_clr_i) begin
      tcount_d = '0;
    end else if (state_q == FIRE && tcount_q != '1) begin
      tcount_d = tcount_q + 32'd1;
    end
  end

  always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      trig_prev_q <= '0;
      coinc_q     <= '0;
      hold_q      <= '0;
      tcount_q    <= '0;
      for (int unsigned i = 0; i < NCHAN; i++) os_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= bus.trig_i;
      coinc_q     <= coinc_d;
      hold_q      <= hold_d;
      tcount_q    <= tcount_d;
      for (int unsigned i = 0; i < NCHAN; i++) os_cnt_q[i] <= os_cnt_d[i];
    end
  end

  assign bus.trigger_o    = (state_q == FIRE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.trig_count_o = tcount_q;

`ifdef RADIANT_TRIG_HIT_LATCH_EN
  // The mask is registered in step with coinc_q, so the latched mask matches the count that fired.
  logic [NCHAN-1:0] act_en_q, hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (state_q == IDLE && state_d == FIRE) hit_d = act_en_q;
  end

  always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_en_q <= '0;
      hit_q    <= '0;
    end else begin
      act_en_q <= act_en;
      hit_q    <= hit_d;
    end
  end

  assign bus.hit_mask_o = hit_q;
`else
  assign bus.hit_mask_o = '0;
`endif
endmodule

// File: tb/tb_radiant_coinc_trigger.sv
// Scoreboard bench for radiant_coinc_trigger: a timestamp-based reference model queues expected fires.
// A negedge monitor matches them against trigger_o.
module tb_radiant_coinc_trigger;
  localparam int NCHAN      = 24;
  localparam int OS_WIDTH   = 7;
  localparam int THR_WIDTH  = 6;
  localparam int HOLD_WIDTH = 8;
  localparam int CMAX       = (1 << THR_WIDTH) - 1;

  typedef struct {
    int               e;
    logic [31:0]      cnt;
    logic [NCHAN-1:0] mask;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  radiant_coinc_trigger_if #(.NCHAN(NCHAN), .OS_WIDTH(OS_WIDTH),
                             .THR_WIDTH(THR_WIDTH), .HOLD_WIDTH(HOLD_WIDTH)) bus ();

  radiant_coinc_trigger #(.NCHAN(NCHAN), .OS_WIDTH(OS_WIDTH),
                          .THR_WIDTH(THR_WIDTH), .HOLD_WIDTH(HOLD_WIDTH)) dut (
    .trig_clk_i (clk),
    .rst_n_i    (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;
  int   seen_fire_edge = -1;
  exp_t exp_q[$];

  // Reference model: a channel is active for len edges after its last rising edge.
  logic [NCHAN-1:0] m_prev;
  int               m_rise [NCHAN];
  int               m_len  [NCHAN];
  int               m_coinc;
  logic [NCHAN-1:0] m_ae;
  logic [31:0]      m_tcount;
  bit               m_busy;
  int               m_fire_edge;
  int               m_rearm_at;

  task automatic model_reset();
    m_prev      = '0;
    m_coinc     = 0;
    m_ae        = '0;
    m_tcount    = '0;
    m_busy      = 1'b0;
    m_fire_edge = -10;
    m_rearm_at  = 0;
    for (int c = 0; c < NCHAN; c++) begin
      m_rise[c] = -1;
      m_len[c]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NCHAN-1:0] act;
    logic [NCHAN-1:0] ae;
    int               pop;
    int               thr;
    exp_t             r;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    act = '0;
    for (int c = 0; c < NCHAN; c++)
      if (m_rise[c] >= 0 && (edge_n - 1 - m_rise[c]) < m_len[c]) act[c] = 1'b1;
    ae  = act & bus.en_i;
    pop = $countones(ae);
    thr = int'(bus.threshold_i);
    if (bus.count_clr_i) m_tcount = '0;
    else if (m_fire_edge == edge_n - 1 && m_tcount != 32'hFFFF_FFFF) m_tcount = m_tcount + 1;
    if (m_fire_edge == edge_n - 1) m_rearm_at = edge_n + int'(bus.holdoff_i);
    if (!m_busy) begin
      if (thr != 0 && m_coinc >= thr) begin
        m_busy      = 1'b1;
        m_fire_edge = edge_n;
        m_rearm_at  = 32'h7FFF_FFFF;
        r.e   = edge_n;
        r.cnt = m_tcount;
`ifdef RADIANT_TRIG_HIT_LATCH_EN
        r.mask = m_ae;
`else
        r.mask = '0;
`endif
        exp_q.push_back(r);
      end
    end else if (edge_n > m_rearm_at && m_coinc < thr) begin
      m_busy = 1'b0;
    end
    for (int c = 0; c < NCHAN; c++)
      if (bus.trig_i[c] && !m_prev[c]) begin
        m_rise[c] = edge_n;
        m_len[c]  = int'(bus.oneshot_len_i);
      end
    m_prev  = bus.trig_i;
    m_coinc = (pop > CMAX) ? CMAX : pop;
    m_ae    = ae;
  endtask

  always @(negedge clk) begin
    exp_t r;
    if (bus.trigger_o) begin
      seen_fire_edge = edge_n;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_trigger edge=%0d", edge_n);
      end else begin
        r = exp_q.pop_front();
        n_checks++;
        if (r.e != edge_n) begin
          n_errors++;
          $display("FAIL fire_edge got=%0d exp=%0d", edge_n, r.e);
        end
        n_checks++;
        if (bus.trig_count_o !== r.cnt) begin
          n_errors++;
          $display("FAIL fire_count got=%0d exp=%0d", bus.trig_count_o, r.cnt);
        end
        n_checks++;
        if (bus.hit_mask_o !== r.mask) begin
          n_errors++;
          $display("FAIL fire_mask got=%h exp=%h", bus.hit_mask_o, r.mask);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
      r = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missed_trigger exp_edge=%0d now=%0d", r.e, edge_n);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int ch);
    bus.trig_i[ch] = 1'b1;
    tick();
    bus.trig_i[ch] = 1'b0;
  endtask

  task automatic cfg(input int len, input int thr, input logic [NCHAN-1:0] en, input int hold);
    bus.oneshot_len_i = OS_WIDTH'(len);
    bus.threshold_i   = THR_WIDTH'(thr);
    bus.en_i          = en;
    bus.holdoff_i     = HOLD_WIDTH'(hold);
  endtask

  task automatic reset_dut();
    bus.trig_i      = '0;
    bus.count_clr_i = 1'b0;
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    seen_fire_edge = -1;
    run(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_trigger"}, 32'(bus.trigger_o), 32'd0);
    check({tag, "_busy"},    32'(bus.busy_o), 32'd0);
    check({tag, "_count"},   bus.trig_count_o, 32'd0);
    check({tag, "_mask"},    32'(bus.hit_mask_o), 32'd0);
  endtask

  initial begin
    int r0, r1;
    logic [NCHAN-1:0] rnd;
    model_reset();
    bus.trig_i = '0;
    bus.count_clr_i = 1'b0;
    cfg(40, 2, 24'h3, 0);
    run(3);
    @(negedge clk);
    check_outputs_zero("reset");

    // Overlapping windows fire two cycles after the second edge
    reset_dut();
    cfg(40, 2, 24'h3, 0);
    pulse(0); r0 = edge_n;
    run(35);
    pulse(1); r1 = edge_n;
    run(60);
    check("overlap_fire_edge", 32'(seen_fire_edge), 32'(r1 + 2));
    check("overlap_count", bus.trig_count_o, 32'd1);

    // Disjoint windows
    reset_dut();
    cfg(40, 2, 24'h3, 0);
    pulse(0); r0 = edge_n;
    run(44);
    pulse(1);
    run(60);
    check("disjoint_count", bus.trig_count_o, 32'd0);
    check("disjoint_no_fire", 32'(seen_fire_edge), 32'hFFFF_FFFF);

    // Held-high input: one fire, busy until the count drops
    reset_dut();
    cfg(40, 1, 24'h1, 10);
    bus.trig_i[0] = 1'b1;
    tick(); r0 = edge_n;
    run(41);
    @(negedge clk);
    check("held_busy_r41", 32'(bus.busy_o), 32'd1);
    tick();
    @(negedge clk);
    check("held_busy_r42", 32'(bus.busy_o), 32'd0);
    run(57);
    bus.trig_i[0] = 1'b0;
    run(60);
    check("held_count", bus.trig_count_o, 32'd1);
    check("held_fire_edge", 32'(seen_fire_edge), 32'(r0 + 2));

    // Masked channel and zero threshold
    reset_dut();
    cfg(40, 1, 24'h1, 0);
    pulse(2);
    run(50);
    check("masked_count", bus.trig_count_o, 32'd0);
    cfg(40, 0, 24'h1, 0);
    pulse(0);
    run(50);
    check("thr0_count", bus.trig_count_o, 32'd0);
    check("thr0_no_fire", 32'(seen_fire_edge), 32'hFFFF_FFFF);

    // Clear on the FIRE cycle, then asynchronous reset inside HOLDOFF
    reset_dut();
    cfg(20, 1, 24'h1, 10);
    pulse(0); r0 = edge_n;
    run(2);
    bus.count_clr_i = 1'b1;
    tick();
    bus.count_clr_i = 1'b0;
    @(negedge clk);
    check("clr_on_fire_count", bus.trig_count_o, 32'd0);
    check("clr_fire_edge", 32'(seen_fire_edge), 32'(r0 + 2));
    run(3);
    check("holdoff_busy", 32'(bus.busy_o), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    run(2);
    rst_n = 1'b1;
    seen_fire_edge = -1;
    run(30);
    check("abort_no_fire", 32'(seen_fire_edge), 32'hFFFF_FFFF);

    // Latched hit mask from channels 0 and 5
    reset_dut();
    cfg(10, 2, '1, 0);
    bus.trig_i = 24'h000021;
    tick();
    bus.trig_i = '0;
    run(20);
    check("hit_fire_count", bus.trig_count_o, 32'd1);
`ifdef RADIANT_TRIG_HIT_LATCH_EN
    check("hit_mask", 32'(bus.hit_mask_o), 32'h0000_0021);
`else
    check("hit_mask", 32'(bus.hit_mask_o), 32'h0000_0000);
`endif

    // Randomized traffic against the reference model
    reset_dut();
    for (int blk = 0; blk < 10; blk++) begin
      cfg($urandom_range(0, 25), $urandom_range(0, 4), NCHAN'($urandom | $urandom), $urandom_range(0, 6));
      for (int i = 0; i < 300; i++) begin
        rnd = NCHAN'($urandom & $urandom & $urandom & $urandom);
        bus.trig_i      = bus.trig_i ^ rnd;
        bus.count_clr_i = ($urandom_range(0, 49) == 0);
        tick();
      end
    end
    bus.trig_i = '0;
    bus.count_clr_i = 1'b0;
    bus.threshold_i = THR_WIDTH'(1);
    run(80);
    check("rand_pending_fires", 32'(exp_q.size()), 32'd0);
    check("rand_final_count", bus.trig_count_o, m_tcount);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
